// File: rtl/mvu_apb_bridge.sv
// rtl/mvu_apb_bridge.sv - ICB to APB bridge for the MVU window with local IRQ latch
//
// Ports:
//   clk, rst_n            single clock, synchronous active-low reset
//   icb_cmd_*             core command channel (valid/ready, addr, read, wdata, wmask)
//   icb_rsp_*             core response channel (valid/ready, err, rdata)
//   mvu_apb_*             APB master towards the MVU (no pready, single-cycle ACCESS)
//   mvu_irq               raw level interrupt from the MVU
//   mvu_irq_o             latched interrupt towards the PLIC
module mvu_apb_bridge #(
    parameter logic [31:0] MVU_BASE = 32'h1004_0000,
    parameter logic [11:0] IRQ_OFS  = 12'hFFC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        icb_cmd_valid,
    output logic        icb_cmd_ready,
    input  logic [31:0] icb_cmd_addr,
    input  logic        icb_cmd_read,
    input  logic [31:0] icb_cmd_wdata,
    input  logic [3:0]  icb_cmd_wmask,
    output logic        icb_rsp_valid,
    input  logic        icb_rsp_ready,
    output logic        icb_rsp_err,
    output logic [31:0] icb_rsp_rdata,
    output logic [31:0] mvu_apb_paddr,
    output logic        mvu_apb_pwrite,
    output logic        mvu_apb_pselx,
    output logic        mvu_apb_penable,
    output logic [31:0] mvu_apb_pwdata,
    input  logic [31:0] mvu_apb_prdata,
    input  logic        mvu_irq,
    output logic        mvu_irq_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state;
    logic   irq_q;
    logic   irq_pend;
    logic   cmd_fire;
    logic   in_window;
    logic   is_local;
    logic   is_fwd;
    logic   irq_rise;
    logic   irq_clr;

    // Ready is gated by rst_n so it reads 0 throughout reset and 1 as soon as
    // reset is released with the FSM already parked in IDLE.
    assign icb_cmd_ready = rst_n && (state == IDLE);
    assign cmd_fire      = icb_cmd_valid && icb_cmd_ready;

    always_comb begin
        in_window = (icb_cmd_addr[31:12] == MVU_BASE[31:12]);
        is_local  = in_window && (icb_cmd_addr[11:0] == IRQ_OFS);
        // Only aligned full-word accesses are forwarded; APB has no strobes here.
        is_fwd    = in_window && !is_local && (icb_cmd_addr[1:0] == 2'b00)
                    && (icb_cmd_read || (icb_cmd_wmask == 4'hF));
        irq_rise  = mvu_irq && !irq_q;
        // The local register ignores wmask; only wdata[0] matters.
        irq_clr   = cmd_fire && is_local && !icb_cmd_read && icb_cmd_wdata[0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            mvu_apb_paddr   <= 32'h0;
            mvu_apb_pwrite  <= 1'b0;
            mvu_apb_pwdata  <= 32'h0;
            mvu_apb_pselx   <= 1'b0;
            mvu_apb_penable <= 1'b0;
            icb_rsp_valid   <= 1'b0;
            icb_rsp_err     <= 1'b0;
            icb_rsp_rdata   <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        if (is_fwd) begin
                            mvu_apb_paddr   <= icb_cmd_addr;
                            mvu_apb_pwrite  <= !icb_cmd_read;
                            mvu_apb_pwdata  <= icb_cmd_wdata;
                            mvu_apb_pselx   <= 1'b1;
                            mvu_apb_penable <= 1'b0;
                            state           <= SETUP;
                        end else begin
                            // Local or rejected command: answer directly, no APB cycle.
                            icb_rsp_valid <= 1'b1;
                            icb_rsp_err   <= !is_local;
                            icb_rsp_rdata <= (is_local && icb_cmd_read) ? {31'b0, irq_pend} : 32'h0;
                            state         <= RESP;
                        end
                    end
                end
                SETUP: begin
                    mvu_apb_penable <= 1'b1;
                    state           <= ACCESS;
                end
                ACCESS: begin
                    // No pready: the slave must deliver prdata in this one cycle.
                    mvu_apb_pselx   <= 1'b0;
                    mvu_apb_penable <= 1'b0;
                    icb_rsp_valid   <= 1'b1;
                    icb_rsp_err     <= 1'b0;
                    icb_rsp_rdata   <= mvu_apb_pwrite ? 32'h0 : mvu_apb_prdata;
                    state           <= RESP;
                end
                RESP: begin
                    if (icb_rsp_ready) begin
                        icb_rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_q    <= 1'b0;
            irq_pend <= 1'b0;
        end else begin
            irq_q <= mvu_irq;
            // A new rising edge beats a simultaneous software clear.
            if (irq_rise) begin
                irq_pend <= 1'b1;
            end else if (irq_clr) begin
                irq_pend <= 1'b0;
            end
        end
    end

    assign mvu_irq_o = irq_pend;

endmodule

// File: tb/tb_mvu_apb_bridge.sv
// tb/tb_mvu_apb_bridge.sv - self-checking bench for mvu_apb_bridge
module tb_mvu_apb_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        icb_cmd_valid;
    logic        icb_cmd_ready;
    logic [31:0] icb_cmd_addr;
    logic        icb_cmd_read;
    logic [31:0] icb_cmd_wdata;
    logic [3:0]  icb_cmd_wmask;
    logic        icb_rsp_valid;
    logic        icb_rsp_ready;
    logic        icb_rsp_err;
    logic [31:0] icb_rsp_rdata;
    logic [31:0] mvu_apb_paddr;
    logic        mvu_apb_pwrite;
    logic        mvu_apb_pselx;
    logic        mvu_apb_penable;
    logic [31:0] mvu_apb_pwdata;
    logic [31:0] mvu_apb_prdata;
    logic        mvu_irq;
    logic        mvu_irq_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mvu_apb_bridge dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .icb_cmd_valid   (icb_cmd_valid),
        .icb_cmd_ready   (icb_cmd_ready),
        .icb_cmd_addr    (icb_cmd_addr),
        .icb_cmd_read    (icb_cmd_read),
        .icb_cmd_wdata   (icb_cmd_wdata),
        .icb_cmd_wmask   (icb_cmd_wmask),
        .icb_rsp_valid   (icb_rsp_valid),
        .icb_rsp_ready   (icb_rsp_ready),
        .icb_rsp_err     (icb_rsp_err),
        .icb_rsp_rdata   (icb_rsp_rdata),
        .mvu_apb_paddr   (mvu_apb_paddr),
        .mvu_apb_pwrite  (mvu_apb_pwrite),
        .mvu_apb_pselx   (mvu_apb_pselx),
        .mvu_apb_penable (mvu_apb_penable),
        .mvu_apb_pwdata  (mvu_apb_pwdata),
        .mvu_apb_prdata  (mvu_apb_prdata),
        .mvu_irq         (mvu_irq),
        .mvu_irq_o       (mvu_irq_o)
    );

    typedef struct {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] prdata;
        logic        exp_fwd;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          hold;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic txn(input logic rd, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wmask, input logic [31:0] prdata,
                       input logic exp_fwd, input logic exp_err, input logic [31:0] exp_rdata,
                       input int hold);
        int   lat;
        logic psel_seen;
        @(negedge clk);
        icb_cmd_valid  = 1'b1;
        icb_cmd_read   = rd;
        icb_cmd_addr   = addr;
        icb_cmd_wdata  = wdata;
        icb_cmd_wmask  = wmask;
        mvu_apb_prdata = prdata;
        icb_rsp_ready  = 1'b0;
        chk("cmd_ready_idle", {31'b0, icb_cmd_ready}, 32'h1);
        @(posedge clk);
        #1;
        icb_cmd_valid = 1'b0;
        lat       = 1;
        psel_seen = 1'b0;
        while (!icb_rsp_valid && lat < 10) begin
            if (mvu_apb_pselx) psel_seen = 1'b1;
            if (lat == 1) begin
                chk("setup_psel", {31'b0, mvu_apb_pselx}, 32'h1);
                chk("setup_penable", {31'b0, mvu_apb_penable}, 32'h0);
                chk("setup_paddr", mvu_apb_paddr, addr);
                chk("setup_pwrite", {31'b0, mvu_apb_pwrite}, {31'b0, !rd});
                if (!rd) chk("setup_pwdata", mvu_apb_pwdata, wdata);
            end
            if (lat == 2) begin
                chk("access_psel", {31'b0, mvu_apb_pselx}, 32'h1);
                chk("access_penable", {31'b0, mvu_apb_penable}, 32'h1);
                chk("access_paddr", mvu_apb_paddr, addr);
            end
            @(posedge clk);
            #1;
            lat++;
        end
        chk("rsp_latency", lat, exp_fwd ? 32'd3 : 32'd1);
        chk("psel_seen", {31'b0, psel_seen}, {31'b0, exp_fwd});
        chk("rsp_err", {31'b0, icb_rsp_err}, {31'b0, exp_err});
        chk("rsp_rdata", icb_rsp_rdata, exp_rdata);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", {31'b0, icb_rsp_valid}, 32'h1);
            chk("hold_rdata", icb_rsp_rdata, exp_rdata);
            chk("hold_err", {31'b0, icb_rsp_err}, {31'b0, exp_err});
            chk("hold_cmd_ready", {31'b0, icb_cmd_ready}, 32'h0);
        end
        icb_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        icb_rsp_ready = 1'b0;
        chk("rsp_done_valid", {31'b0, icb_rsp_valid}, 32'h0);
        chk("rsp_done_ready", {31'b0, icb_cmd_ready}, 32'h1);
    endtask

    initial begin
        //          rd    addr          wdata         wm    prdata        fwd   err   rdata         hold
        vecs[0] = '{1'b0, 32'h1004_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,        1'b1, 1'b0, 32'h0,        0};
        vecs[1] = '{1'b1, 32'h1004_0020, 32'h0,         4'h0, 32'h1234_5678, 1'b1, 1'b0, 32'h1234_5678, 4};
        vecs[2] = '{1'b0, 32'h2000_0000, 32'h1111_1111, 4'hF, 32'h0,        1'b0, 1'b1, 32'h0,        0};
        vecs[3] = '{1'b0, 32'h1004_0004, 32'h2222_2222, 4'h3, 32'h0,        1'b0, 1'b1, 32'h0,        0};
        vecs[4] = '{1'b1, 32'h1004_0002, 32'h0,         4'hF, 32'h5555_5555, 1'b0, 1'b1, 32'h0,        0};
        vecs[5] = '{1'b1, 32'h1004_0FFC, 32'h0,         4'hF, 32'h7777_7777, 1'b0, 1'b0, 32'h0,        0};
        vecs[6] = '{1'b1, 32'h1004_0008, 32'h0,         4'h0, 32'hA5A5_0F0F, 1'b1, 1'b0, 32'hA5A5_0F0F, 1};
        vecs[7] = '{1'b0, 32'h1004_0FFC, 32'h0,         4'h0, 32'h0,        1'b0, 1'b0, 32'h0,        0};

        rst_n          = 1'b0;
        icb_cmd_valid  = 1'b0;
        icb_cmd_addr   = 32'h0;
        icb_cmd_read   = 1'b0;
        icb_cmd_wdata  = 32'h0;
        icb_cmd_wmask  = 4'h0;
        icb_rsp_ready  = 1'b0;
        mvu_apb_prdata = 32'h0;
        mvu_irq        = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", {31'b0, icb_cmd_ready}, 32'h0);
        chk("rst_pselx", {31'b0, mvu_apb_pselx}, 32'h0);
        chk("rst_penable", {31'b0, mvu_apb_penable}, 32'h0);
        chk("rst_pwrite", {31'b0, mvu_apb_pwrite}, 32'h0);
        chk("rst_paddr", mvu_apb_paddr, 32'h0);
        chk("rst_pwdata", mvu_apb_pwdata, 32'h0);
        chk("rst_rsp_valid", {31'b0, icb_rsp_valid}, 32'h0);
        chk("rst_rsp_err", {31'b0, icb_rsp_err}, 32'h0);
        chk("rst_rsp_rdata", icb_rsp_rdata, 32'h0);
        chk("rst_irq_o", {31'b0, mvu_irq_o}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_cmd_ready", {31'b0, icb_cmd_ready}, 32'h1);

        for (int v = 0; v < 8; v++) begin
            txn(vecs[v].rd, vecs[v].addr, vecs[v].wdata, vecs[v].wmask, vecs[v].prdata,
                vecs[v].exp_fwd, vecs[v].exp_err, vecs[v].exp_rdata, vecs[v].hold);
        end

        // Interrupt latch: set, read back, clear, level held high does not re-set.
        @(negedge clk);
        mvu_irq = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("irq_set", {31'b0, mvu_irq_o}, 32'h1);
        txn(1'b1, 32'h1004_0FFC, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0, 32'h1, 0);
        txn(1'b0, 32'h1004_0FFC, 32'h1, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 0);
        chk("irq_cleared", {31'b0, mvu_irq_o}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("irq_level_no_reset", {31'b0, mvu_irq_o}, 32'h0);
        txn(1'b1, 32'h1004_0FFC, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 0);
        @(negedge clk);
        mvu_irq = 1'b0;
        repeat (2) @(negedge clk);
        mvu_irq = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("irq_reedge", {31'b0, mvu_irq_o}, 32'h1);

        // Clear write accepted on the same edge as a new rising edge: set wins.
        txn(1'b0, 32'h1004_0FFC, 32'h1, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 0);
        @(negedge clk);
        mvu_irq = 1'b0;
        repeat (2) @(negedge clk);
        chk("irq_pre_race", {31'b0, mvu_irq_o}, 32'h0);
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = 1'b0;
        icb_cmd_addr  = 32'h1004_0FFC;
        icb_cmd_wdata = 32'h1;
        icb_cmd_wmask = 4'hF;
        mvu_irq       = 1'b1;
        @(posedge clk);
        #1;
        icb_cmd_valid = 1'b0;
        chk("race_rsp_valid", {31'b0, icb_rsp_valid}, 32'h1);
        chk("race_irq_kept", {31'b0, mvu_irq_o}, 32'h1);
        icb_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        icb_rsp_ready = 1'b0;
        chk("race_irq_after", {31'b0, mvu_irq_o}, 32'h1);

        // Reset during ACCESS abandons the read; a fresh read then works.
        @(negedge clk);
        icb_cmd_valid  = 1'b1;
        icb_cmd_read   = 1'b1;
        icb_cmd_addr   = 32'h1004_0030;
        mvu_apb_prdata = 32'h0BAD_0BAD;
        @(posedge clk);
        #1;
        icb_cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_access_penable", {31'b0, mvu_apb_penable}, 32'h1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_pselx", {31'b0, mvu_apb_pselx}, 32'h0);
        chk("mid_rst_penable", {31'b0, mvu_apb_penable}, 32'h0);
        chk("mid_rst_rsp_valid", {31'b0, icb_rsp_valid}, 32'h0);
        chk("mid_rst_cmd_ready", {31'b0, icb_cmd_ready}, 32'h0);
        chk("mid_rst_irq_o", {31'b0, mvu_irq_o}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rel_cmd_ready", {31'b0, icb_cmd_ready}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("no_stale_rsp", {31'b0, icb_rsp_valid}, 32'h0);
        end
        txn(1'b1, 32'h1004_0040, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b1, 1'b0, 32'hCAFE_F00D, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
